// File: rtl/sa_2d_seq_ctrl_if.sv
// Beat input channel of sa_2d_seq_ctrl: one A column and one B row per transfer.
// A beat moves on a cycle where in_valid and in_ready are both high; in_valid must hold its beat until then.
interface sa_2d_seq_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int HPE   = 4,
    parameter int VPE   = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH*HPE-1:0]   in_a;
    logic [WIDTH*VPE-1:0]   in_b;

    modport master (output in_valid, output in_a, output in_b, input in_ready);
    modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/sa_2d_seq_ctrl.sv
// Operand sequencer for the sa_2D output-stationary array: skews beats, drains, captures Y.
// Optional FEED stall counter enabled by defining SA_SEQ_STALL_CNT_EN.
module sa_2d_seq_ctrl #(
    parameter int WIDTH   = 32,
    parameter int HPE     = 4,
    parameter int VPE     = 4,
    parameter int MAC_LAT = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          start,
    input  logic [7:0]                    k_len,
    sa_2d_seq_ctrl_if.slave               beat,
    output logic [WIDTH*HPE-1:0]          AA,
    output logic [WIDTH*VPE-1:0]          BB,
    output logic                          sa_rst_n,
    input  logic [2*WIDTH*HPE*VPE-1:0]    y_in,
    output logic [2*WIDTH*HPE*VPE-1:0]    y_out,
    output logic                          y_valid,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   stall_cnt,
    output logic [2:0]                    state_dbg
);
    localparam int D  = HPE + VPE - 1 + MAC_LAT;
    localparam int DW = $clog2(D + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t          state, state_next;
    logic [7:0]      k_len_q;
    logic [7:0]      beat_cnt;
    logic [DW-1:0]   drain_cnt;
    logic            start_acc, beat_acc, last_beat, drain_last;

    assign start_acc  = (state == IDLE) && start && (k_len != 8'd0);
    assign beat_acc   = (state == FEED) && beat.in_valid;
    assign last_beat  = (beat_cnt == k_len_q - 8'd1);
    assign drain_last = (drain_cnt == DW'(D - 1));

    assign beat.in_ready = (state == FEED);
    assign busy          = (state != IDLE);
    assign state_dbg     = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_acc) state_next = CLEAR;
            CLEAR:   state_next = FEED;
            FEED:    if (beat_acc && last_beat) state_next = DRAIN;
            DRAIN:   if (drain_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // sa_rst_n is registered from next state so it is low exactly during CLEAR.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            k_len_q   <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            sa_rst_n  <= 1'b0;
            done      <= 1'b0;
            y_valid   <= 1'b0;
            y_out     <= '0;
        end else begin
            sa_rst_n <= (state_next != CLEAR);
            done     <= (state == DONE);
            if (start_acc) begin
                k_len_q <= k_len;
                y_valid <= 1'b0;
            end
            if (state == CLEAR)  beat_cnt <= '0;
            else if (beat_acc)   beat_cnt <= beat_cnt + 8'd1;
            if (state == DRAIN)  drain_cnt <= drain_cnt + DW'(1);
            else                 drain_cnt <= '0;
            if (state == DONE) begin
                y_out   <= y_in;
                y_valid <= 1'b1;
            end
        end
    end

    // Lane n sits behind n+1 registers; idle cycles shift zeros into the wavefront.
    for (genvar n = 0; n < HPE; n++) begin : g_a_skew
        logic [WIDTH-1:0] sr [n+1];
        always_ff @(posedge CLK or posedge RST) begin
            if (RST || state == CLEAR) begin
                for (int s = 0; s <= n; s++) sr[s] <= '0;
            end else begin
                sr[0] <= beat_acc ? beat.in_a[n*WIDTH +: WIDTH] : '0;
                for (int s = 1; s <= n; s++) sr[s] <= sr[s-1];
            end
        end
        assign AA[n*WIDTH +: WIDTH] = sr[n];
    end

    for (genvar n = 0; n < VPE; n++) begin : g_b_skew
        logic [WIDTH-1:0] sr [n+1];
        always_ff @(posedge CLK or posedge RST) begin
            if (RST || state == CLEAR) begin
                for (int s = 0; s <= n; s++) sr[s] <= '0;
            end else begin
                sr[0] <= beat_acc ? beat.in_b[n*WIDTH +: WIDTH] : '0;
                for (int s = 1; s <= n; s++) sr[s] <= sr[s-1];
            end
        end
        assign BB[n*WIDTH +: WIDTH] = sr[n];
    end

`ifdef SA_SEQ_STALL_CNT_EN
    logic [15:0] stall_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stall_q <= '0;
        else if (state == CLEAR)
            stall_q <= '0;
        else if (state == FEED && !beat.in_valid && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end
    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
